// File: rtl/jericalla_pipe_param_if.sv
// Instruction handshake and retirement reporting bundle for jericalla_pipe_param.
// The master side is the instruction source and observer; the slave side is the datapath.
interface jericalla_pipe_param_if #(
    parameter int DW    = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    localparam int IW = 3 + 3 * RA_W;

    logic             instr_valid;
    logic [IW-1:0]    instr;
    logic             instr_ready;
    logic             zf;
    logic             wb_valid;
    logic [RA_W-1:0]  wb_addr;
    logic [DW-1:0]    wb_data;
    logic [CNT_W-1:0] retired_count;

    modport master (
        output instr_valid, instr,
        input  instr_ready, zf, wb_valid, wb_addr, wb_data, retired_count
    );

    modport slave (
        input  instr_valid, instr,
        output instr_ready, zf, wb_valid, wb_addr, wb_data, retired_count
    );
endinterface

// File: rtl/jericalla_pipe_param.sv
// Three-stage datapath (ID/EX, EX/WB, retire) with forwarding, load-use stall,
// register file, ALU and asynchronously read data RAM.
module jericalla_pipe_param #(
    parameter int DW     = 32,
    parameter int RA_W   = 5,
    parameter int MEM_AW = 6,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    jericalla_pipe_param_if.slave bus
);
    localparam int NREG  = 2 ** RA_W;
    localparam int IW    = 3 + 3 * RA_W;
    localparam int DEPTH = 2 ** MEM_AW;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SW  = 3'b101,
        OP_LW  = 3'b110,
        OP_LI  = 3'b111
    } op_t;

    logic [DW-1:0]    r_rf  [NREG];
    logic [DW-1:0]    r_mem [DEPTH];

    logic             r_ex_valid;
    op_t              r_ex_op;
    logic [RA_W-1:0]  r_ex_rd;
    logic [DW-1:0]    r_ex_a;
    logic [DW-1:0]    r_ex_b;

    logic             r_wb_valid;
    op_t              r_wb_op;
    logic [RA_W-1:0]  r_wb_rd;
    logic [DW-1:0]    r_wb_res;
    logic [DW-1:0]    r_wb_sdata;

    logic             r_zf;
    logic             r_out_valid;
    logic [RA_W-1:0]  r_out_addr;
    logic [DW-1:0]    r_out_data;
    logic [CNT_W-1:0] r_count;

    op_t              w_op;
    logic [RA_W-1:0]  w_rd;
    logic [RA_W-1:0]  w_rs1;
    logic [RA_W-1:0]  w_rs2;
    logic [DW-1:0]    w_imm;
    logic [DW-1:0]    w_rs1_val;
    logic [DW-1:0]    w_rs2_val;
    logic [DW-1:0]    w_alu;
    logic [DW-1:0]    w_wb_val;
    logic             w_ex_wr;
    logic             w_wb_wr;
    logic             w_stall;
    logic             w_accept;
    logic             w_ex_is_alu;

    assign w_op  = op_t'(bus.instr[IW-1 -: 3]);
    assign w_rd  = bus.instr[3*RA_W-1 -: RA_W];
    assign w_rs1 = bus.instr[2*RA_W-1 -: RA_W];
    assign w_rs2 = bus.instr[RA_W-1:0];
    assign w_imm = DW'({w_rs1, w_rs2});

    // An LW in EX never forwards: any consumer of its rd is held back one cycle instead.
    assign w_ex_wr  = r_ex_valid && (r_ex_op != OP_SW) && (r_ex_op != OP_LW) && (r_ex_rd != '0);
    assign w_wb_wr  = r_wb_valid && (r_wb_op != OP_SW) && (r_wb_rd != '0);
    assign w_wb_val = (r_wb_op == OP_LW) ? r_mem[r_wb_res[MEM_AW-1:0]] : r_wb_res;

    assign w_stall = bus.instr_valid && r_ex_valid && (r_ex_op == OP_LW) && (r_ex_rd != '0)
                     && (w_op != OP_LI) && ((w_rs1 == r_ex_rd) || (w_rs2 == r_ex_rd));
    assign bus.instr_ready = !rst && !w_stall;
    assign w_accept        = bus.instr_valid && bus.instr_ready;

    always_comb begin
        w_rs1_val = r_rf[w_rs1];
        if (w_rs1 == '0)
            w_rs1_val = '0;
        else if (w_ex_wr && (r_ex_rd == w_rs1))
            w_rs1_val = w_alu;
        else if (w_wb_wr && (r_wb_rd == w_rs1))
            w_rs1_val = w_wb_val;

        w_rs2_val = r_rf[w_rs2];
        if (w_rs2 == '0)
            w_rs2_val = '0;
        else if (w_ex_wr && (r_ex_rd == w_rs2))
            w_rs2_val = w_alu;
        else if (w_wb_wr && (r_wb_rd == w_rs2))
            w_rs2_val = w_wb_val;
    end

    // SW/LW pass the address operand through so WB can index the RAM.
    always_comb begin
        w_alu       = r_ex_a;
        w_ex_is_alu = 1'b1;
        case (r_ex_op)
            OP_ADD: w_alu = r_ex_a + r_ex_b;
            OP_SUB: w_alu = r_ex_a - r_ex_b;
            OP_AND: w_alu = r_ex_a & r_ex_b;
            OP_OR:  w_alu = r_ex_a | r_ex_b;
            OP_SLT: w_alu = DW'($signed(r_ex_a) < $signed(r_ex_b));
            OP_LI: begin
                w_alu       = r_ex_b;
                w_ex_is_alu = 1'b0;
            end
            default: w_ex_is_alu = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                r_rf[i] <= '0;
            r_ex_valid  <= 1'b0;
            r_ex_op     <= OP_ADD;
            r_ex_rd     <= '0;
            r_ex_a      <= '0;
            r_ex_b      <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_op     <= OP_ADD;
            r_wb_rd     <= '0;
            r_wb_res    <= '0;
            r_wb_sdata  <= '0;
            r_zf        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_count     <= '0;
        end else begin
            r_ex_valid <= w_accept;
            r_ex_op    <= w_op;
            r_ex_rd    <= w_rd;
            r_ex_a     <= (w_op == OP_LI) ? '0 : w_rs1_val;
            r_ex_b     <= (w_op == OP_LI) ? w_imm : w_rs2_val;

            r_wb_valid <= r_ex_valid;
            r_wb_op    <= r_ex_op;
            r_wb_rd    <= r_ex_rd;
            r_wb_res   <= w_alu;
            r_wb_sdata <= r_ex_b;
            if (r_ex_valid && w_ex_is_alu)
                r_zf <= (w_alu == '0);

            if (w_wb_wr)
                r_rf[r_wb_rd] <= w_wb_val;

            r_out_valid <= r_wb_valid;
            if (r_wb_valid) begin
                r_count    <= r_count + 1'b1;
                r_out_addr <= (r_wb_op == OP_SW) ? '0 : r_wb_rd;
                if (r_wb_op == OP_SW)
                    r_out_data <= r_wb_sdata;
                else if (r_wb_rd == '0)
                    r_out_data <= '0;
                else
                    r_out_data <= w_wb_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_wb_valid && (r_wb_op == OP_SW))
            r_mem[r_wb_res[MEM_AW-1:0]] <= r_wb_sdata;
    end

    assign bus.zf            = r_zf;
    assign bus.wb_valid      = r_out_valid;
    assign bus.wb_addr       = r_out_addr;
    assign bus.wb_data       = r_out_data;
    assign bus.retired_count = r_count;
endmodule

// File: tb/tb_jericalla_pipe_param.sv
// Directed bench for jericalla_pipe_param: a vector table run back-to-back,
// plus hand-written zero-flag and mid-flight reset sequences.
module tb_jericalla_pipe_param;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, SLT = 3'b100;
    localparam logic [2:0] SW  = 3'b101, LW  = 3'b110, LI  = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    ret_t rq[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    jericalla_pipe_param_if bus ();

    jericalla_pipe_param dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always begin
        @(posedge clk);
        #1;
        if (bus.wb_valid) rq.push_back('{addr: bus.wb_addr, data: bus.wb_data});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [4:0] rd, rs1, rs2,
                                input logic [4:0] ea, input logic [31:0] ed, input int es);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.exp_addr = ea; v.exp_data = ed; v.exp_stall = es;
        return v;
    endfunction

    // Presents one instruction, counting cycles with ready low, and returns after acceptance.
    task automatic send(input logic [2:0] op, input logic [4:0] rd, rs1, rs2, output int stalls);
        stalls = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = {op, rd, rs1, rs2};
        #1;
        while (!bus.instr_ready && stalls < 10) begin
            stalls++;
            @(posedge clk);
            #1;
        end
        if (stalls >= 10) chk("accept_timeout", stalls, 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_addr", bus.wb_addr, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_zf", bus.zf, 0);
        chk("rst_count", bus.retired_count, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus.instr_ready, 1);
        rq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st, tot;
        ret_t r;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;

        vecs[0]  = mk(LI,  1, 0, 5,   1, 32'd5, 0);
        vecs[1]  = mk(LI,  2, 0, 3,   2, 32'd3, 0);
        vecs[2]  = mk(ADD, 3, 1, 2,   3, 32'd8, 0);
        vecs[3]  = mk(SUB, 4, 1, 1,   4, 32'd0, 0);
        vecs[4]  = mk(LI,  5, 0, 1,   5, 32'd1, 0);
        vecs[5]  = mk(SW,  0, 2, 1,   0, 32'd5, 0);
        vecs[6]  = mk(LW,  5, 2, 0,   5, 32'd5, 0);
        vecs[7]  = mk(ADD, 6, 5, 1,   6, 32'd10, 1);
        vecs[8]  = mk(SUB, 7, 0, 1,   7, 32'hFFFF_FFFB, 0);
        vecs[9]  = mk(SLT, 8, 7, 1,   8, 32'd1, 0);
        vecs[10] = mk(SLT, 9, 1, 7,   9, 32'd0, 0);
        vecs[11] = mk(LI,  0, 0, 7,   0, 32'd0, 0);
        vecs[12] = mk(ADD, 10, 0, 0, 10, 32'd0, 0);

        do_reset();
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, st);
            chk($sformatf("stall[%0d]", i), st, vecs[i].exp_stall);
        end
        drain();
        chk("table_ret_count", rq.size(), 13);
        chk("table_counter", bus.retired_count, 13);
        chk("table_zf", bus.zf, 1);
        foreach (vecs[i]) begin
            if (i < rq.size()) begin
                chk($sformatf("wb_addr[%0d]", i), rq[i].addr, vecs[i].exp_addr);
                chk($sformatf("wb_data[%0d]", i), rq[i].data, vecs[i].exp_data);
            end
        end

        do_reset();
        tot = 0;
        send(LI, 1, 0, 5, st); tot += st;
        send(LI, 2, 0, 3, st); tot += st;
        send(ADD, 3, 1, 2, st); tot += st;
        drain();
        chk("fwd_stalls", tot, 0);
        chk("fwd_count", bus.retired_count, 3);
        chk("fwd_addr", bus.wb_addr, 3);
        chk("fwd_data", bus.wb_data, 8);
        chk("fwd_zf", bus.zf, 0);
        send(SUB, 4, 1, 1, st);
        drain();
        chk("sub_data", bus.wb_data, 0);
        chk("sub_zf", bus.zf, 1);
        send(LI, 5, 0, 1, st);
        drain();
        chk("li_data", bus.wb_data, 1);
        chk("li_keeps_zf", bus.zf, 1);
        chk("li_count", bus.retired_count, 5);

        rq.delete();
        send(LI, 1, 0, 9, st);
        rst = 1'b1;
        #1;
        chk("midrst_ready", bus.instr_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain();
        chk("midrst_no_retire", rq.size(), 0);
        chk("midrst_count", bus.retired_count, 0);
        send(ADD, 2, 1, 0, st);
        drain();
        chk("post_rst_retires", rq.size(), 1);
        if (rq.size() > 0) begin
            r = rq[0];
            chk("post_rst_addr", r.addr, 2);
            chk("post_rst_data", r.data, 0);
        end
        chk("post_rst_count", bus.retired_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
